// File: rtl/ctrl_sequencer_if.sv
// Control-sequencer bus: fetch, decode outputs, datapath strobes, memory handshake.
// master = sequencer side (drives PC, strobes); slave = ROM/datapath/memory side.
// Widths follow PC_W, which must match the sequencer's PC_W.
interface ctrl_sequencer_if #(parameter int PC_W = 10);
   logic            start;
   logic [8:0]      INSTR;
   logic            EQUAL;
   logic            mem_ready;
   logic [PC_W-1:0] PC;
   logic            fetch_req;
   logic [3:0]      OP;
   logic            type_bit;
   logic [3:0]      reg_idx;
   logic            acc_we;
   logic            reg_we;
   logic            mem_re;
   logic            mem_we;
   logic            done;

   modport master (
      input  start, INSTR, EQUAL, mem_ready,
      output PC, fetch_req, OP, type_bit, reg_idx,
             acc_we, reg_we, mem_re, mem_we, done
   );

   modport slave (
      output start, INSTR, EQUAL, mem_ready,
      input  PC, fetch_req, OP, type_bit, reg_idx,
             acc_we, reg_we, mem_re, mem_we, done
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the 8-bit accumulator processor (FETCH/DECODE/EXEC/MEM).
// Latency: 3 cycles per non-memory instruction, 3+N for load/store (N MEM cycles).
// Backpressure: MEM holds mem_re/mem_we until mem_ready; start only honoured in IDLE/HALT.
module ctrl_sequencer #(
   parameter int PC_W = 10
) (
   input  logic             CLK,
   input  logic             Reset,
   ctrl_sequencer_if.master bus
);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;

   localparam logic [3:0] OP_PUT   = 4'b0001;
   localparam logic [3:0] OP_LOAD  = 4'b0010;
   localparam logic [3:0] OP_STORE = 4'b0011;
   localparam logic [3:0] OP_EQL   = 4'b1010;
   localparam logic [3:0] OP_OF0   = 4'b1101;
   localparam logic [3:0] OP_HALT  = 4'b1110;
   localparam logic [PC_W-1:0] PC_ONE = 1;

   state_t          state, state_nxt;
   logic [8:0]      ir;
   logic            ir_ld;
   logic            flag, flag_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [PC_W-1:0] br_ofs;
   logic [3:0]      op;
   logic            is_branch, is_load;
   logic            fetch_req_c, acc_we_c, reg_we_c, mem_re_c, mem_we_c, done_c;

   assign op        = ir[7:4];
   assign is_branch = ir[8];
   assign is_load   = !ir[8] && (op == OP_LOAD);
   // 8-bit branch offset is signed; 0x80 is -128
   assign br_ofs    = PC_W'($signed(ir[7:0]));

   // State, PC, flag and instruction register; reset clears all of them at once
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         pc    <= '0;
         flag  <= 1'b0;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         flag  <= flag_nxt;
         if (ir_ld) ir <= bus.INSTR;
      end
   end

   // Next-state, PC/flag update and strobes decoded from state and IR
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      flag_nxt    = flag;
      ir_ld       = 1'b0;
      fetch_req_c = 1'b0;
      acc_we_c    = 1'b0;
      reg_we_c    = 1'b0;
      mem_re_c    = 1'b0;
      mem_we_c    = 1'b0;
      done_c      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = FETCH;
               pc_nxt    = '0;
               flag_nxt  = 1'b0;
            end
         end
         FETCH: begin
            fetch_req_c = 1'b1;
            state_nxt   = DECODE;
         end
         DECODE: begin
            ir_ld     = 1'b1;
            state_nxt = EXEC;
         end
         EXEC: begin
            if (is_branch) begin
               state_nxt = FETCH;
               pc_nxt    = flag ? (pc + br_ofs) : (pc + PC_ONE);
            end else begin
               case (op)
                  OP_LOAD, OP_STORE: state_nxt = MEM;
                  OP_HALT:           state_nxt = HALT;
                  default: begin
                     state_nxt = FETCH;
                     pc_nxt    = pc + PC_ONE;
                     case (op)
                        OP_PUT:  reg_we_c = 1'b1;
                        OP_EQL:  flag_nxt = bus.EQUAL;
                        OP_OF0:  flag_nxt = 1'b0;
                        default: acc_we_c = 1'b1;
                     endcase
                  end
               endcase
            end
         end
         MEM: begin
            if (is_load) begin
               mem_re_c = 1'b1;
               acc_we_c = bus.mem_ready;
            end else begin
               mem_we_c = 1'b1;
            end
            if (bus.mem_ready) begin
               state_nxt = FETCH;
               pc_nxt    = pc + PC_ONE;
            end
         end
         HALT: begin
            done_c = 1'b1;
            if (bus.start) begin
               state_nxt = FETCH;
               pc_nxt    = '0;
               flag_nxt  = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.PC        = pc;
   assign bus.fetch_req = fetch_req_c;
   assign bus.OP        = ir[7:4];
   assign bus.type_bit  = ir[8];
   assign bus.reg_idx   = ir[3:0];
   assign bus.acc_we    = acc_we_c;
   assign bus.reg_we    = reg_we_c;
   assign bus.mem_re    = mem_re_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.done      = done_c;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: expected fetch addresses are queued as each
// program is loaded and popped by a monitor on every fetch; per-cycle strobe,
// decode and PC checks run inline in the stimulus sequence.
module tb_ctrl_sequencer;
   localparam int PC_W = 10;

   logic CLK = 1'b0;
   logic Reset;
   int   tests = 0;
   int   fails = 0;
   int   exp_pc_q[$];
   logic [8:0] rom [0:(1<<PC_W)-1];

   ctrl_sequencer_if #(.PC_W(PC_W)) bus ();

   ctrl_sequencer #(.PC_W(PC_W)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Instruction ROM: data valid the cycle after fetch_req
   always @(posedge CLK) begin
      if (bus.fetch_req === 1'b1) bus.INSTR <= rom[bus.PC];
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_fetch(input int exp_pc, input string tag);
      int n = 0;
      tick();
      while (bus.fetch_req !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      check({tag, " fetch"}, {31'd0, bus.fetch_req}, 1);
      check({tag, " pc"}, {{(32-PC_W){1'b0}}, bus.PC}, exp_pc);
   endtask

   // Scoreboard monitor: every fetch must match the next queued address; strobes stay exclusive
   always @(negedge CLK) begin
      if (Reset === 1'b0) begin
         if (bus.fetch_req === 1'b1) begin
            tests++;
            assert (exp_pc_q.size() > 0) else begin
               fails++;
               $error("FAIL sb_unexpected_fetch: got pc %0d expected no fetch", bus.PC);
            end
            if (exp_pc_q.size() > 0) begin
               int e;
               e = exp_pc_q.pop_front();
               tests++;
               assert (int'(bus.PC) === e) else begin
                  fails++;
                  $error("FAIL sb_fetch_pc: got %0d expected %0d", bus.PC, e);
               end
            end
         end
         tests++;
         assert (($countones({bus.acc_we, bus.reg_we, bus.mem_we}) <= 1) &&
                 !(bus.mem_re && bus.mem_we)) else begin
            fails++;
            $error("FAIL strobe_excl: got acc/reg/re/we %b%b%b%b expected exclusive",
                   bus.acc_we, bus.reg_we, bus.mem_re, bus.mem_we);
         end
      end
   end

   initial begin
      int seq1[13] = '{0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 9};
      int seq2[6]  = '{0, 1, 10, 906, 1023, 0};

      for (int i = 0; i < (1 << PC_W); i++) rom[i] = 9'h0E0;
      Reset         = 1'b1;
      bus.start     = 1'b0;
      bus.EQUAL     = 1'b0;
      bus.mem_ready = 1'b0;

      // ---- reset state ----
      tick();
      tick();
      check("rst pc",        {22'd0, bus.PC}, 0);
      check("rst fetch_req", {31'd0, bus.fetch_req}, 0);
      check("rst op",        {28'd0, bus.OP}, 0);
      check("rst type_bit",  {31'd0, bus.type_bit}, 0);
      check("rst reg_idx",   {28'd0, bus.reg_idx}, 0);
      check("rst strobes",   {28'd0, bus.acc_we, bus.reg_we, bus.mem_re, bus.mem_we}, 0);
      check("rst done",      {31'd0, bus.done}, 0);
      Reset = 1'b0;
      tick();
      check("idle no fetch", {31'd0, bus.fetch_req}, 0);

      // ---- program 1: take, store, put, xor, eql/branch loop, of0, halt ----
      rom[0] = 9'h003;  // take r3
      rom[1] = 9'h032;  // store r2
      rom[2] = 9'h014;  // put r4
      rom[3] = 9'h041;  // xor r1
      rom[4] = 9'h0A0;  // eql
      rom[5] = 9'h1FE;  // branch -2
      rom[6] = 9'h0A0;  // eql
      rom[7] = 9'h0D0;  // of0
      rom[8] = 9'h1FE;  // branch -2
      rom[9] = 9'h0E0;  // halt
      foreach (seq1[i]) exp_pc_q.push_back(seq1[i]);

      bus.start = 1'b1;
      tick();                                   // cycle 1: FETCH
      bus.start = 1'b0;
      check("take c1 fetch", {31'd0, bus.fetch_req}, 1);
      check("take c1 pc",    {22'd0, bus.PC}, 0);
      tick();                                   // DECODE
      check("take c2 fetch", {31'd0, bus.fetch_req}, 0);
      check("take c2 acc_we", {31'd0, bus.acc_we}, 0);
      tick();                                   // EXEC
      check("take c3 acc_we",  {31'd0, bus.acc_we}, 1);
      check("take c3 reg_idx", {28'd0, bus.reg_idx}, 3);
      check("take c3 op",      {28'd0, bus.OP}, 0);
      tick();                                   // FETCH pc 1
      check("take c4 fetch", {31'd0, bus.fetch_req}, 1);
      check("take c4 pc",    {22'd0, bus.PC}, 1);

      tick();
      tick();                                   // EXEC store
      check("store exec no strobe", {28'd0, bus.acc_we, bus.reg_we, bus.mem_re, bus.mem_we}, 0);
      for (int i = 0; i < 4; i++) begin
         tick();                                // MEM cycles
         if (i == 3) bus.mem_ready = 1'b1;
         check("store mem_we", {31'd0, bus.mem_we}, 1);
         check("store no acc_we", {31'd0, bus.acc_we}, 0);
         check("store pc hold", {22'd0, bus.PC}, 1);
      end
      tick();
      bus.mem_ready = 1'b0;
      check("store done mem_we", {31'd0, bus.mem_we}, 0);
      check("store done pc", {22'd0, bus.PC}, 2);

      tick();
      tick();                                   // EXEC put
      check("put reg_we",  {31'd0, bus.reg_we}, 1);
      check("put reg_idx", {28'd0, bus.reg_idx}, 4);
      check("put acc_we",  {31'd0, bus.acc_we}, 0);
      wait_fetch(3, "xor");
      tick();
      tick();
      check("xor acc_we", {31'd0, bus.acc_we}, 1);
      check("xor op",     {28'd0, bus.OP}, 4);
      wait_fetch(4, "eql1");
      bus.EQUAL = 1'b1;
      tick();
      tick();
      check("eql no write", {30'd0, bus.acc_we, bus.reg_we}, 0);
      check("eql op",       {28'd0, bus.OP}, 4'hA);
      wait_fetch(5, "br1");
      bus.EQUAL = 1'b0;
      tick();
      tick();
      check("br type_bit", {31'd0, bus.type_bit}, 1);
      check("br no write", {30'd0, bus.acc_we, bus.reg_we}, 0);
      wait_fetch(3, "br taken");
      wait_fetch(4, "eql2");
      wait_fetch(5, "br2");
      wait_fetch(6, "br not taken");
      bus.EQUAL = 1'b1;
      wait_fetch(7, "of0");
      bus.EQUAL = 1'b0;
      wait_fetch(8, "br3");
      wait_fetch(9, "of0 cleared flag");
      tick();
      tick();                                   // EXEC halt
      check("halt exec done", {31'd0, bus.done}, 0);
      check("halt exec strobes", {28'd0, bus.acc_we, bus.reg_we, bus.mem_re, bus.mem_we}, 0);
      tick();
      check("halt done", {31'd0, bus.done}, 1);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("halt hold", {21'd0, bus.done, bus.PC}, {21'd0, 1'b1, 10'd9});
      end
      check("sb1 drained", exp_pc_q.size(), 0);

      // ---- program 2: restart from HALT, branch wrap both ways ----
      rom[0]    = 9'h0A0;  // eql
      rom[1]    = 9'h109;  // branch +9 -> 10
      rom[10]   = 9'h180;  // branch -128 -> 906
      rom[906]  = 9'h175;  // branch +117 -> 1023
      rom[1023] = 9'h101;  // branch +1 -> 0
      foreach (seq2[i]) exp_pc_q.push_back(seq2[i]);
      bus.EQUAL = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("restart done", {31'd0, bus.done}, 0);
      check("restart fetch", {31'd0, bus.fetch_req}, 1);
      check("restart pc", {22'd0, bus.PC}, 0);
      wait_fetch(1, "p2 br+9");
      wait_fetch(10, "p2 at 10");
      wait_fetch(906, "p2 wrap -128");
      wait_fetch(1023, "p2 at top");
      wait_fetch(0, "p2 wrap +1");
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      bus.EQUAL = 1'b0;
      check("sb2 drained", exp_pc_q.size(), 0);

      // ---- program 3: load with immediate mem_ready, then reset mid-MEM ----
      rom[0] = 9'h025;  // load r5
      rom[1] = 9'h026;  // load r6
      exp_pc_q.push_back(0);
      exp_pc_q.push_back(1);
      bus.mem_ready = 1'b1;
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();                                   // EXEC load
      check("load exec mem_re", {31'd0, bus.mem_re}, 0);
      tick();                                   // MEM, mem_ready already high
      check("load1 mem_re", {31'd0, bus.mem_re}, 1);
      check("load1 acc_we", {31'd0, bus.acc_we}, 1);
      check("load1 reg_idx", {28'd0, bus.reg_idx}, 5);
      tick();
      bus.mem_ready = 1'b0;
      check("load1 next pc", {22'd0, bus.PC}, 1);
      check("load1 next mem_re", {31'd0, bus.mem_re}, 0);
      tick();
      tick();
      tick();                                   // MEM, waiting
      check("load2 mem_re", {31'd0, bus.mem_re}, 1);
      check("load2 acc_we wait", {31'd0, bus.acc_we}, 0);
      tick();
      check("load2 still mem", {22'd0, bus.PC}, 1);
      Reset     = 1'b1;
      bus.start = 1'b1;
      #1;
      check("arst mem_re", {31'd0, bus.mem_re}, 0);
      check("arst acc_we", {31'd0, bus.acc_we}, 0);
      check("arst pc", {22'd0, bus.PC}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("arst start ignored", {22'd0, bus.fetch_req, bus.PC}, 0);
      end
      bus.start = 1'b0;
      Reset     = 1'b0;
      tick();
      check("post rst idle", {31'd0, bus.fetch_req}, 0);
      check("sb3 drained", exp_pc_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
